systolic_gemm_tile: RTL



---
 rtl/systolic_gemm_tile.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_gemm_tile.sv
// systolic_gemm_tile: output-stationary ROWS x COLS systolic GEMM tile.
// Computes C = A x B for a runtime inner dimension K. The tile skews its own
// operands, tracks per-operand valid bits (bubbles), runs an
// IDLE/LOAD/FLUSH/DRAIN control FSM, and drains one C row per handshake.
// Optional feature macro: SYSTOLIC_SATURATE_EN (saturating accumulators);
// when undefined the accumulators wrap modulo 2^ACC_W.
module systolic_gemm_tile #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int KMAX_W = 16,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [KMAX_W-1:0]        i_k,
    input  logic                     i_signed,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [ROWS*DATA_W-1:0]   i_a,
    input  logic [COLS*DATA_W-1:0]   i_b,
    output logic                     o_busy,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ROW_W-1:0]         o_row,
    output logic [COLS*ACC_W-1:0]    o_c,
    output logic                     o_done
);

    localparam int FL_W  = $clog2(ROWS + COLS) + 1;
    localparam int SUM_W = ACC_W + 2;
    localparam int PRD_W = 2 * DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic [KMAX_W-1:0]   k_reg, k_next;
    logic [KMAX_W-1:0]   beat_reg, beat_next;
    logic                signed_reg, signed_next;
    logic [FL_W-1:0]     flush_reg, flush_next;
    logic [ROW_W-1:0]    row_reg, row_next;
    logic                done_reg, done_next;
    logic                clear;
    logic                accept;

    // Skew outputs feeding the array edges, and inter-PE forwarding nets.
    logic [DATA_W-1:0]   a_in     [ROWS];
    logic                a_in_vld [ROWS];
    logic [DATA_W-1:0]   b_in     [COLS];
    logic                b_in_vld [COLS];
    logic [DATA_W-1:0]   a_fwd     [ROWS][COLS];
    logic                a_fwd_vld [ROWS][COLS];
    logic [DATA_W-1:0]   b_fwd     [ROWS][COLS];
    logic                b_fwd_vld [ROWS][COLS];
    logic [ACC_W-1:0]    acc_out   [ROWS][COLS];

    // Control state register; active-low synchronous reset discards any job.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg  <= ST_IDLE;
            k_reg      <= '0;
            beat_reg   <= '0;
            signed_reg <= 1'b0;
            flush_reg  <= '0;
            row_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            beat_reg   <= beat_next;
            signed_reg <= signed_next;
            flush_reg  <= flush_next;
            row_reg    <= row_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic: start latching, beat counting, flush timer, row drain.
    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        beat_next   = beat_reg;
        signed_next = signed_reg;
        flush_next  = flush_reg;
        row_next    = row_reg;
        done_next   = 1'b0;
        clear       = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    clear       = 1'b1;
                    k_next      = i_k;
                    signed_next = i_signed;
                    beat_next   = '0;
                    flush_next  = '0;
                    row_next    = '0;
                    state_next  = (i_k == '0) ? ST_FLUSH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_valid) begin
                    accept    = 1'b1;
                    beat_next = beat_reg + KMAX_W'(1);
                    if (beat_next == k_reg) begin
                        state_next = ST_FLUSH;
                        flush_next = '0;
                    end
                end
            end
            ST_FLUSH: begin
                // Last beat needs ROWS+COLS-1 edges to reach the far corner PE.
                if (flush_reg == FL_W'(ROWS + COLS - 2)) begin
                    state_next = ST_DRAIN;
                    row_next   = '0;
                end else begin
                    flush_next = flush_reg + FL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (i_ready) begin
                    if (row_reg == ROW_W'(ROWS - 1)) begin
                        state_next = ST_IDLE;
                        row_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        row_next = row_reg + ROW_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_ready = (state_reg == ST_LOAD);
    assign o_busy  = (state_reg != ST_IDLE);
    assign o_valid = (state_reg == ST_DRAIN);
    assign o_row   = row_reg;
    assign o_done  = done_reg;

    // A skew: row gi passes through gi+1 registers so it enters column 0
    // gi cycles after row 0.
    genvar gi, gj;
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic [DATA_W-1:0] data_reg [gi+1];
        logic              vld_reg  [gi+1];

        // Shift chain carrying operand and its valid bit.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n || clear) begin
                for (int s = 0; s <= gi; s++) begin
                    data_reg[s] <= '0;
                    vld_reg[s]  <= 1'b0;
                end
            end else begin
                data_reg[0] <= i_a[gi*DATA_W +: DATA_W];
                vld_reg[0]  <= accept;
                for (int s = 1; s <= gi; s++) begin
                    data_reg[s] <= data_reg[s-1];
                    vld_reg[s]  <= vld_reg[s-1];
                end
            end
        end

        assign a_in[gi]     = data_reg[gi];
        assign a_in_vld[gi] = vld_reg[gi];
    end

    // B skew: column gi delayed by gi cycles relative to column 0.
    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
        logic [DATA_W-1:0] data_reg [gi+1];
        logic              vld_reg  [gi+1];

        // Shift chain carrying operand and its valid bit.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n || clear) begin
                for (int s = 0; s <= gi; s++) begin
                    data_reg[s] <= '0;
                    vld_reg[s]  <= 1'b0;
                end
            end else begin
                data_reg[0] <= i_b[gi*DATA_W +: DATA_W];
                vld_reg[0]  <= accept;
                for (int s = 1; s <= gi; s++) begin
                    data_reg[s] <= data_reg[s-1];
                    vld_reg[s]  <= vld_reg[s-1];
                end
            end
        end

        assign b_in[gi]     = data_reg[gi];
        assign b_in_vld[gi] = vld_reg[gi];
    end

    // Processing elements: A flows right, B flows down, C stays put.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_pe
            logic [DATA_W-1:0]       a_cur, b_cur;
            logic                    a_cur_vld, b_cur_vld;
            logic [DATA_W-1:0]       a_reg, b_reg;
            logic                    a_vld_reg, b_vld_reg;
            logic [ACC_W-1:0]        acc_reg, acc_next;
            logic signed [DATA_W:0]  a_ext, b_ext;
            logic signed [PRD_W-1:0] prod;
            logic signed [SUM_W-1:0] prod_w;

            if (gj == 0) begin : g_a_edge
                assign a_cur     = a_in[gi];
                assign a_cur_vld = a_in_vld[gi];
            end else begin : g_a_mid
                assign a_cur     = a_fwd[gi][gj-1];
                assign a_cur_vld = a_fwd_vld[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_cur     = b_in[gj];
                assign b_cur_vld = b_in_vld[gj];
            end else begin : g_b_mid
                assign b_cur     = b_fwd[gi-1][gj];
                assign b_cur_vld = b_fwd_vld[gi-1][gj];
            end

            // One extra bit lets a single signed multiplier serve both modes.
            assign a_ext  = {signed_reg & a_cur[DATA_W-1], a_cur};
            assign b_ext  = {signed_reg & b_cur[DATA_W-1], b_cur};
            assign prod   = PRD_W'(a_ext) * PRD_W'(b_ext);
            assign prod_w = SUM_W'(prod);

`ifdef SYSTOLIC_SATURATE_EN
            logic signed [SUM_W-1:0] acc_w, sum_w;
            assign acc_w = {{2{signed_reg & acc_reg[ACC_W-1]}}, acc_reg};
            assign sum_w = acc_w + prod_w;

            // Clamp the widened sum to the signed or unsigned ACC_W range.
            always_comb begin
                acc_next = sum_w[ACC_W-1:0];
                if (signed_reg) begin
                    if ((sum_w[SUM_W-1:ACC_W-1] != '0) &&
                        (sum_w[SUM_W-1:ACC_W-1] != '1)) begin
                        acc_next = sum_w[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                  : {1'b0, {(ACC_W-1){1'b1}}};
                    end
                end else begin
                    if (sum_w[SUM_W-1:ACC_W] != '0) begin
                        acc_next = '1;
                    end
                end
            end
`else
            assign acc_next = acc_reg + prod_w[ACC_W-1:0];
`endif

            // Operand forwarding and MAC only when both operands are real.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n || clear) begin
                    a_reg     <= '0;
                    b_reg     <= '0;
                    a_vld_reg <= 1'b0;
                    b_vld_reg <= 1'b0;
                    acc_reg   <= '0;
                end else begin
                    a_reg     <= a_cur;
                    b_reg     <= b_cur;
                    a_vld_reg <= a_cur_vld;
                    b_vld_reg <= b_cur_vld;
                    if (a_cur_vld && b_cur_vld) begin
                        acc_reg <= acc_next;
                    end
                end
            end

            assign a_fwd[gi][gj]     = a_reg;
            assign a_fwd_vld[gi][gj] = a_vld_reg;
            assign b_fwd[gi][gj]     = b_reg;
            assign b_fwd_vld[gi][gj] = b_vld_reg;
            assign acc_out[gi][gj]   = acc_reg;
        end
    end

    // Result row mux; zero outside DRAIN.
    for (gi = 0; gi < COLS; gi++) begin : g_out
        assign o_c[gi*ACC_W +: ACC_W] = (state_reg == ST_DRAIN) ? acc_out[row_reg][gi] : '0;
    end

endmodule
